// File: rtl/led_panel_sequencer.sv
// Step sequencer for the per-colour PWM panel datapath: sweeps pwm_time, drives the
// PISO load/shift strobes and the driver-chip sclk/latch/mode/blank, and walks the layers.
module led_panel_sequencer #(
   parameter  int SHIFT_WIDTH = 16,
   parameter  int CLK_DIV     = 2,
   parameter  int LAYERS      = 16,
   localparam int LAYER_BITS  = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  brightness_req,
   output logic [7:0]            pwm_time,
   output logic                  load_led_vals,
   output logic                  load_brightness,
   output logic                  shift,
   output logic                  sclk,
   output logic                  latch,
   output logic                  mode,
   output logic                  blank_n,
   output logic [LAYER_BITS-1:0] layer,
   output logic                  frame_done
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;
   localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]      BIT_LAST   = BIT_W'(SHIFT_WIDTH - 1);
   localparam logic [LAYER_BITS-1:0] LAYER_LAST = LAYER_BITS'(LAYERS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BRT_LOAD,
      S_BRT_SHIFT,
      S_BRT_LATCH,
      S_LOAD,
      S_SHIFT,
      S_LATCH,
      S_NEXT
   } state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic                  hi_q, hi_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [7:0]            pwm_q, pwm_d;
   logic [LAYER_BITS-1:0] layer_q, layer_d;
   logic                  pend_q, pend_d;
   logic                  clr_pend;

   logic load_led_q, load_led_d;
   logic load_brt_q, load_brt_d;
   logic shift_q, shift_d;
   logic sclk_q, sclk_d;
   logic latch_q, latch_d;
   logic mode_q, mode_d;
   logic blank_q, blank_d;
   logic frame_q, frame_d;
   logic shifting_d;
   logic wrap_d;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      hi_d     = hi_q;
      bit_d    = bit_q;
      pwm_d    = pwm_q;
      layer_d  = layer_q;
      clr_pend = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (enable) state_d = pend_q ? S_BRT_LOAD : S_LOAD;
         end
         S_BRT_LOAD, S_LOAD: begin
            state_d = (state_q == S_LOAD) ? S_SHIFT : S_BRT_SHIFT;
            div_d   = '0;
            hi_d    = 1'b0;
            bit_d   = '0;
         end
         S_BRT_SHIFT, S_SHIFT: begin
            // Each bit: CLK_DIV cycles low, then CLK_DIV cycles high.
            if (div_q == DIV_LAST) begin
               div_d = '0;
               hi_d  = ~hi_q;
               if (hi_q) begin
                  if (bit_q == BIT_LAST)
                     state_d = (state_q == S_SHIFT) ? S_LATCH : S_BRT_LATCH;
                  else
                     bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_BRT_LATCH, S_LATCH: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (state_q == S_BRT_LATCH) begin
                  state_d  = S_LOAD;
                  clr_pend = 1'b1;
               end else begin
                  state_d = S_NEXT;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_NEXT: begin
            pwm_d = pwm_q + 8'd1;
            if (pwm_q == 8'hFF)
               layer_d = (layer_q == LAYER_LAST) ? '0 : layer_q + LAYER_BITS'(1);
            if (!enable)     state_d = S_IDLE;
            else if (pend_q) state_d = S_BRT_LOAD;
            else             state_d = S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase

      pend_d = brightness_req | (pend_q & ~clr_pend);

      // Outputs are decoded from the upcoming state so they land registered.
      shifting_d = (state_d == S_SHIFT) || (state_d == S_BRT_SHIFT);
      load_led_d = (state_d == S_LOAD);
      load_brt_d = (state_d == S_BRT_LOAD);
      sclk_d     = shifting_d & hi_d;
      shift_d    = shifting_d & hi_d & (div_d == DIV_LAST);
      latch_d    = (state_d == S_LATCH) || (state_d == S_BRT_LATCH);
      mode_d     = state_d inside {S_BRT_LOAD, S_BRT_SHIFT, S_BRT_LATCH};
      wrap_d     = (state_d == S_NEXT) && (pwm_d == 8'hFF);
      blank_d    = (state_d inside {S_LOAD, S_SHIFT, S_LATCH}) ||
                   ((state_d == S_NEXT) && !wrap_d);
      frame_d    = wrap_d && (layer_d == LAYER_LAST);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         hi_q       <= 1'b0;
         bit_q      <= '0;
         pwm_q      <= '0;
         layer_q    <= '0;
         pend_q     <= 1'b1;
         load_led_q <= 1'b0;
         load_brt_q <= 1'b0;
         shift_q    <= 1'b0;
         sclk_q     <= 1'b0;
         latch_q    <= 1'b0;
         mode_q     <= 1'b0;
         blank_q    <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         hi_q       <= hi_d;
         bit_q      <= bit_d;
         pwm_q      <= pwm_d;
         layer_q    <= layer_d;
         pend_q     <= pend_d;
         load_led_q <= load_led_d;
         load_brt_q <= load_brt_d;
         shift_q    <= shift_d;
         sclk_q     <= sclk_d;
         latch_q    <= latch_d;
         mode_q     <= mode_d;
         blank_q    <= blank_d;
         frame_q    <= frame_d;
      end
   end

   assign pwm_time        = pwm_q;
   assign layer           = layer_q;
   assign load_led_vals   = load_led_q;
   assign load_brightness = load_brt_q;
   assign shift           = shift_q;
   assign sclk            = sclk_q;
   assign latch           = latch_q;
   assign mode            = mode_q;
   assign blank_n         = blank_q;
   assign frame_done      = frame_q;

endmodule
